// File: rtl/bitlogic_serial_unit.sv
// Bit-serial 2-input logic unit: evaluates AND/OR/XOR/XNOR/NAND/NOR/BUF/INV one bit per
// clock, LSB first, through a single 1-bit slice, and returns the word plus its parity.
module bitlogic_serial_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid/data must be held until that edge and ready never depends on valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic [2:0]       op_q;
    logic             par_q;
    logic [CW-1:0]    idx_q;
    logic             last_bit;
    logic             r_bit;

    function automatic logic slice(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a ^ b);
            3'b100:  r = ~(a & b);
            3'b101:  r = ~(a | b);
            3'b110:  r = a;
            default: r = ~a;
        endcase
        return r;
    endfunction

    assign last_bit = (idx_q == CW'(WIDTH - 1));
    assign r_bit    = slice(op_q, a_q[idx_q], b_q[idx_q]);

    // Bits above idx are still zero, so on the last bit this is the finished word.
    always_comb begin
        res_next        = res_q;
        res_next[idx_q] = r_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            par_q      <= 1'b0;
            idx_q      <= '0;
            out_data   <= '0;
            out_parity <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        op_q  <= in_op;
                        res_q <= '0;
                        par_q <= 1'b0;
                        idx_q <= '0;
                    end
                end
                SHIFT: begin
                    res_q <= res_next;
                    par_q <= par_q ^ r_bit;
                    if (last_bit) begin
                        idx_q      <= '0;
                        out_data   <= res_next;
                        out_parity <= par_q ^ r_bit;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
